// File: rtl/decoder_bmp.sv
// Byte-serial 24-bit uncompressed BMP parser: validates the header, drops the gap
// and row padding, and emits one {R,G,B} pixel per three data bytes with position flags.
module decoder_bmp #(
    parameter logic [15:0] MAX_WIDTH      = 16'd1024,
    parameter logic [15:0] MAX_HEIGHT     = 16'd1024,
    parameter int          ROW_ALIGN_LOG2 = 2,
    parameter logic [31:0] MAX_OFFSET     = 32'd1023
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_n_i,
    input  logic        decoder_start_i,
    output logic        decoder_ready_o,
    input  logic        bmp_data_vaild_i,
    input  logic [7:0]  bmp_data_i,
    output logic        pix_valid_o,
    output logic [23:0] pix_data_o,
    output logic [15:0] pix_x_o,
    output logic [15:0] pix_y_o,
    output logic        pix_eol_o,
    output logic        pix_eof_o,
    output logic [15:0] img_width_o,
    output logic [15:0] img_height_o,
    output logic        decoder_done_o,
    output logic        decoder_err_o,
    output logic [2:0]  err_code_o
);

    localparam int RA = ROW_ALIGN_LOG2;
    localparam logic [RA-1:0] PAD_ONE = RA'(1);

    typedef enum logic [2:0] {S_IDLE, S_HEAD, S_SKIP, S_DATA, S_PAD, S_DONE, S_ERR} state_t;
    typedef enum logic [2:0] {E_NONE, E_SIG, E_OFFSET, E_DIM, E_BPP, E_COMP} err_t;

    state_t         state, state_nxt;
    err_t           fail_code;
    logic           fail;
    logic [5:0]     hdr_cnt;
    logic [31:0]    skip_cnt;
    logic [31:0]    offset;
    logic [23:0]    field_buf;
    logic [31:0]    cur_word;
    logic [1:0]     phase;
    logic [7:0]     pix_b, pix_g;
    logic [15:0]    col_cnt, row_cnt;
    logic [RA-1:0]  pad_cnt, pad_len, row_low;
    logic           row_last, img_last, pad_last;

    // Last four header bytes as a little-endian word, newest byte on top.
    assign cur_word = {bmp_data_i, field_buf};

    // Padding depends only on 3W modulo the alignment, so only the low width bits matter.
    assign row_low  = img_width_o[RA-1:0] + img_width_o[RA-1:0] + img_width_o[RA-1:0];
    assign pad_len  = {RA{1'b0}} - row_low;
    assign row_last = (col_cnt == img_width_o - 16'd1);
    assign img_last = (row_cnt == img_height_o - 16'd1);
    assign pad_last = (pad_cnt == pad_len - PAD_ONE);

    assign decoder_ready_o = sys_rst_n_i && (state == S_IDLE);
    assign decoder_done_o  = (state == S_DONE);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        fail      = 1'b0;
        fail_code = E_NONE;
        case (state)
            S_IDLE: if (decoder_start_i) state_nxt = S_HEAD;
            S_HEAD: if (bmp_data_vaild_i) begin
                case (hdr_cnt)
                    6'd0:  if (bmp_data_i != 8'h42) begin fail = 1'b1; fail_code = E_SIG; end
                    6'd1:  if (bmp_data_i != 8'h4D) begin fail = 1'b1; fail_code = E_SIG; end
                    6'd13: if (cur_word < 32'd54 || cur_word > MAX_OFFSET) begin
                        fail = 1'b1; fail_code = E_OFFSET;
                    end
                    6'd21: if (cur_word == 32'd0 || cur_word[31:16] != 16'd0 ||
                               cur_word[15:0] > MAX_WIDTH) begin
                        fail = 1'b1; fail_code = E_DIM;
                    end
                    6'd25: if (cur_word == 32'd0 || cur_word[31:16] != 16'd0 ||
                               cur_word[15:0] > MAX_HEIGHT) begin
                        fail = 1'b1; fail_code = E_DIM;
                    end
                    6'd29: if (cur_word[31:16] != 16'd24) begin fail = 1'b1; fail_code = E_BPP; end
                    6'd33: if (cur_word != 32'd0) begin fail = 1'b1; fail_code = E_COMP; end
                    default: ;
                endcase
                if (fail)                 state_nxt = S_ERR;
                else if (hdr_cnt == 6'd53) state_nxt = (offset > 32'd54) ? S_SKIP : S_DATA;
            end
            S_SKIP: if (bmp_data_vaild_i && skip_cnt == offset - 32'd55) state_nxt = S_DATA;
            S_DATA: if (bmp_data_vaild_i && phase == 2'd2 && row_last) begin
                if (pad_len != '0)  state_nxt = S_PAD;
                else if (img_last)  state_nxt = S_DONE;
            end
            S_PAD:  if (bmp_data_vaild_i && pad_last) state_nxt = img_last ? S_DONE : S_DATA;
            S_DONE: state_nxt = S_IDLE;
            S_ERR:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            state        <= S_IDLE;
            hdr_cnt      <= '0;
            skip_cnt     <= '0;
            offset       <= '0;
            field_buf    <= '0;
            phase        <= '0;
            pix_b        <= '0;
            pix_g        <= '0;
            col_cnt      <= '0;
            row_cnt      <= '0;
            pad_cnt      <= '0;
            pix_valid_o  <= 1'b0;
            pix_data_o   <= '0;
            pix_x_o      <= '0;
            pix_y_o      <= '0;
            pix_eol_o    <= 1'b0;
            pix_eof_o    <= 1'b0;
            img_width_o  <= '0;
            img_height_o <= '0;
            decoder_err_o <= 1'b0;
            err_code_o   <= '0;
        end else begin
            state       <= state_nxt;
            pix_valid_o <= 1'b0;
            pix_eol_o   <= 1'b0;
            pix_eof_o   <= 1'b0;
            case (state)
                S_IDLE: if (decoder_start_i) begin
                    hdr_cnt       <= '0;
                    skip_cnt      <= '0;
                    offset        <= '0;
                    phase         <= '0;
                    col_cnt       <= '0;
                    row_cnt       <= '0;
                    pad_cnt       <= '0;
                    img_width_o   <= '0;
                    img_height_o  <= '0;
                    decoder_err_o <= 1'b0;
                    err_code_o    <= '0;
                end
                S_HEAD: if (bmp_data_vaild_i) begin
                    hdr_cnt   <= hdr_cnt + 6'd1;
                    field_buf <= cur_word[31:8];
                    if (hdr_cnt == 6'd13) offset       <= cur_word;
                    if (hdr_cnt == 6'd21) img_width_o  <= cur_word[15:0];
                    if (hdr_cnt == 6'd25) img_height_o <= cur_word[15:0];
                    if (fail) begin
                        decoder_err_o <= 1'b1;
                        err_code_o    <= fail_code;
                    end
                end
                S_SKIP: if (bmp_data_vaild_i) skip_cnt <= skip_cnt + 32'd1;
                S_DATA: if (bmp_data_vaild_i) begin
                    case (phase)
                        2'd0: begin pix_b <= bmp_data_i; phase <= 2'd1; end
                        2'd1: begin pix_g <= bmp_data_i; phase <= 2'd2; end
                        default: begin
                            pix_valid_o <= 1'b1;
                            pix_data_o  <= {bmp_data_i, pix_g, pix_b};
                            pix_x_o     <= col_cnt;
                            pix_y_o     <= row_cnt;
                            pix_eol_o   <= row_last;
                            pix_eof_o   <= row_last && img_last;
                            phase       <= 2'd0;
                            if (row_last) begin
                                col_cnt <= '0;
                                pad_cnt <= '0;
                                if (pad_len == '0 && !img_last) row_cnt <= row_cnt + 16'd1;
                            end else begin
                                col_cnt <= col_cnt + 16'd1;
                            end
                        end
                    endcase
                end
                S_PAD: if (bmp_data_vaild_i) begin
                    pad_cnt <= pad_cnt + PAD_ONE;
                    if (pad_last && !img_last) row_cnt <= row_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
